// File: rtl/ev22_regfile.sv
// EV22 register file: GPRs, r32..r34, two output ports, two synchronised input ports; 1W/2R.
// Latency: operands registered one edge after updateBlock; writes land on their edge, same-edge bypass.
// No backpressure: strobes are accepted every cycle; bad writes are dropped and flagged on wr_err.
module ev22_regfile #(
  parameter int DATA_W = 16,
  parameter int N_GPR  = 28,
  parameter int SEL_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              updateBlock,
  input  logic [SEL_W-1:0]  Sel_A,
  input  logic [SEL_W-1:0]  Sel_B,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] pi0,
  input  logic [DATA_W-1:0] pi1,
  output logic [DATA_W-1:0] Data_A,
  output logic [DATA_W-1:0] Data_B,
  output logic              data_valid,
  output logic [DATA_W-1:0] po0,
  output logic [DATA_W-1:0] po1,
  output logic              wr_err
);

  localparam int GI_W = (N_GPR > 1) ? $clog2(N_GPR) : 1;

  localparam logic [SEL_W-1:0] A_PI0 = SEL_W'(28);
  localparam logic [SEL_W-1:0] A_PI1 = SEL_W'(29);
  localparam logic [SEL_W-1:0] A_PO0 = SEL_W'(30);
  localparam logic [SEL_W-1:0] A_PO1 = SEL_W'(31);
  localparam logic [SEL_W-1:0] A_R32 = SEL_W'(32);
  localparam logic [SEL_W-1:0] A_R33 = SEL_W'(33);
  localparam logic [SEL_W-1:0] A_R34 = SEL_W'(34);
  localparam logic [SEL_W-1:0] A_GPR = SEL_W'(N_GPR);

  logic [DATA_W-1:0] gpr [N_GPR];
  logic [DATA_W-1:0] r32, r33, r34;
  logic [DATA_W-1:0] pi0_s1, pi0_s2, pi1_s1, pi1_s2;

  logic              wr_ok;
  logic              byp_a, byp_b;
  logic [DATA_W-1:0] rd_a, rd_b;

  function automatic logic is_writable(input logic [SEL_W-1:0] a);
    return (a < A_GPR) || (a >= A_PO0 && a <= A_R34);
  endfunction

  // Input ports read the second synchroniser flop; unmapped addresses read as zero.
  function automatic logic [DATA_W-1:0] rd_sel(input logic [SEL_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a < A_GPR) begin
      v = gpr[a[GI_W-1:0]];
    end else begin
      case (a)
        A_PI0:   v = pi0_s2;
        A_PI1:   v = pi1_s2;
        A_PO0:   v = po0;
        A_PO1:   v = po1;
        A_R32:   v = r32;
        A_R33:   v = r33;
        A_R34:   v = r34;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  always_comb begin
    wr_ok = wr_en && is_writable(wr_addr);
    byp_a = wr_ok && (Sel_A == wr_addr);
    byp_b = wr_ok && (Sel_B == wr_addr);
    rd_a  = byp_a ? wr_data : rd_sel(Sel_A);
    rd_b  = byp_b ? wr_data : rd_sel(Sel_B);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpr        <= '{default: '0};
      r32        <= '0;
      r33        <= '0;
      r34        <= '0;
      po0        <= '0;
      po1        <= '0;
      pi0_s1     <= '0;
      pi0_s2     <= '0;
      pi1_s1     <= '0;
      pi1_s2     <= '0;
      Data_A     <= '0;
      Data_B     <= '0;
      data_valid <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      pi0_s1     <= pi0;
      pi0_s2     <= pi0_s1;
      pi1_s1     <= pi1;
      pi1_s2     <= pi1_s1;
      data_valid <= updateBlock;
      wr_err     <= wr_en && !wr_ok;
      if (updateBlock) begin
        Data_A <= rd_a;
        Data_B <= rd_b;
      end
      if (wr_ok) begin
        if (wr_addr < A_GPR) begin
          gpr[wr_addr[GI_W-1:0]] <= wr_data;
        end else begin
          case (wr_addr)
            A_PO0:   po0 <= wr_data;
            A_PO1:   po1 <= wr_data;
            A_R32:   r32 <= wr_data;
            A_R33:   r33 <= wr_data;
            A_R34:   r34 <= wr_data;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ev22_regfile.sv
// Self-checking bench for ev22_regfile: default instance plus an N_GPR=8, DATA_W=32 instance.
module tb_ev22_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        updateBlock, wr_en;
  logic [5:0]  Sel_A, Sel_B, wr_addr;
  logic [15:0] wr_data, pi0, pi1;
  logic [15:0] Data_A, Data_B, po0, po1;
  logic        data_valid, wr_err;

  logic        p_updateBlock, p_wr_en;
  logic [5:0]  p_Sel_A, p_Sel_B, p_wr_addr;
  logic [31:0] p_wr_data, p_pi0, p_pi1;
  logic [31:0] p_Data_A, p_Data_B, p_po0, p_po1;
  logic        p_data_valid, p_wr_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ea, eb;

  always #5 clk = ~clk;

  ev22_regfile dut (
    .clk(clk), .reset(reset), .updateBlock(updateBlock), .Sel_A(Sel_A), .Sel_B(Sel_B),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pi0(pi0), .pi1(pi1),
    .Data_A(Data_A), .Data_B(Data_B), .data_valid(data_valid), .po0(po0), .po1(po1),
    .wr_err(wr_err)
  );

  ev22_regfile #(.DATA_W(32), .N_GPR(8), .SEL_W(6)) dut_p (
    .clk(clk), .reset(reset), .updateBlock(p_updateBlock), .Sel_A(p_Sel_A), .Sel_B(p_Sel_B),
    .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data), .pi0(p_pi0), .pi1(p_pi1),
    .Data_A(p_Data_A), .Data_B(p_Data_B), .data_valid(p_data_valid), .po0(p_po0), .po1(p_po1),
    .wr_err(p_wr_err)
  );

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic strobe(input logic [5:0] a, input logic [5:0] b, input logic [31:0] xa, input logic [31:0] xb);
    @(negedge clk);
    Sel_A = a; Sel_B = b; updateBlock = 1'b1;
    exp_q.push_back(xa); exp_q.push_back(xb);
    @(negedge clk);
    updateBlock = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    updateBlock = 0; wr_en = 0; Sel_A = 0; Sel_B = 0; wr_addr = 0; wr_data = 0; pi0 = 0; pi1 = 0;
    p_updateBlock = 0; p_wr_en = 0; p_Sel_A = 0; p_Sel_B = 0; p_wr_addr = 0; p_wr_data = 0;
    p_pi0 = 0; p_pi1 = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({Data_A, Data_B, po0, po1, data_valid, wr_err} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_state got A=%h B=%h po0=%h po1=%h dv=%b err=%b want all 0",
               Data_A, Data_B, po0, po1, data_valid, wr_err);
    end
    vectors++;
    if ({p_Data_A, p_po1, p_data_valid} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_state_p got A=%h po1=%h dv=%b want 0", p_Data_A, p_po1, p_data_valid);
    end
    reset = 1'b0;
    pi0 = 16'h1111;
  endtask

  task automatic test_reset_unmapped;
    wr(5, 16'h1234);
    strobe(5, 5, 32'h1234, 32'h1234);
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    vectors++;
    if ({16'h0, Data_A} !== ea || data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_read got A=%h dv=%b want %h 1", Data_A, data_valid, ea);
    end
    // Reset lands between edges while a strobe and write are pending.
    @(negedge clk);
    updateBlock = 1'b1; Sel_A = 5; wr_en = 1'b1; wr_addr = 5; wr_data = 16'h9999;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (Data_A !== 16'h0 || data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got A=%h dv=%b want 0 0", Data_A, data_valid);
    end
    @(negedge clk);
    updateBlock = 1'b0; wr_en = 1'b0; reset = 1'b0;
    strobe(5, 40, 32'h0, 32'h0);
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    vectors++;
    if ({16'h0, Data_A} !== ea || {16'h0, Data_B} !== eb || data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_unmapped_read got A=%h B=%h dv=%b want %h %h 1", Data_A, Data_B, data_valid, ea, eb);
    end
    @(negedge clk);
    vectors++;
    if (data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dv_single_pulse got %b want 0", data_valid);
    end
  endtask

  task automatic test_write_read;
    wr(27, 16'hBEEF);
    wr(34, 16'hCAFE);
    strobe(27, 34, 32'hBEEF, 32'hCAFE);
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    vectors++;
    if ({16'h0, Data_A} !== ea || {16'h0, Data_B} !== eb || data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL write_read got A=%h B=%h dv=%b want %h %h 1", Data_A, Data_B, data_valid, ea, eb);
    end
    wr(30, 16'h0F0F);
    vectors++;
    if (po0 !== 16'h0F0F) begin
      miscompares++;
      $display("FAIL po0_write got %h want 0f0f", po0);
    end
    wr(32, 16'h0001);
    wr(33, 16'h0002);
    strobe(32, 33, 32'h1, 32'h2);
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    vectors++;
    if ({16'h0, Data_A} !== ea || {16'h0, Data_B} !== eb) begin
      miscompares++;
      $display("FAIL r32_r33 got A=%h B=%h want %h %h", Data_A, Data_B, ea, eb);
    end
    wr(32, 16'h1357);
    vectors++;
    if (Data_A !== 16'h0001 || data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_after_write got A=%h dv=%b want 0001 0", Data_A, data_valid);
    end
  endtask

  task automatic test_bypass;
    wr(3, 16'h0001);
    @(negedge clk);
    wr_en = 1; wr_addr = 3; wr_data = 16'h00FF; updateBlock = 1; Sel_A = 3; Sel_B = 3;
    exp_q.push_back(32'hFF); exp_q.push_back(32'hFF);
    @(negedge clk);
    wr_en = 0; updateBlock = 0;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    vectors++;
    if ({16'h0, Data_A} !== ea || {16'h0, Data_B} !== eb) begin
      miscompares++;
      $display("FAIL bypass_gpr got A=%h B=%h want %h %h", Data_A, Data_B, ea, eb);
    end
    strobe(3, 3, 32'hFF, 32'hFF);
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    vectors++;
    if ({16'h0, Data_A} !== ea || {16'h0, Data_B} !== eb) begin
      miscompares++;
      $display("FAIL after_bypass got A=%h B=%h want %h %h", Data_A, Data_B, ea, eb);
    end
    @(negedge clk);
    wr_en = 1; wr_addr = 34; wr_data = 16'h7777; updateBlock = 1; Sel_A = 34; Sel_B = 3;
    exp_q.push_back(32'h7777); exp_q.push_back(32'hFF);
    @(negedge clk);
    wr_en = 0; updateBlock = 0;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    vectors++;
    if ({16'h0, Data_A} !== ea || {16'h0, Data_B} !== eb) begin
      miscompares++;
      $display("FAIL bypass_r34 got A=%h B=%h want %h %h", Data_A, Data_B, ea, eb);
    end
    @(negedge clk);
    wr_en = 1; wr_addr = 28; wr_data = 16'hBBBB; updateBlock = 1; Sel_A = 28; Sel_B = 28;
    exp_q.push_back(32'h1111); exp_q.push_back(32'h1111);
    @(negedge clk);
    wr_en = 0; updateBlock = 0;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    vectors++;
    if ({16'h0, Data_A} !== ea || {16'h0, Data_B} !== eb || wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL no_bypass_pi0 got A=%h B=%h err=%b want %h %h 1", Data_A, Data_B, wr_err, ea, eb);
    end
  endtask

  task automatic test_read_only;
    wr(28, 16'hAAAA);
    vectors++;
    if (wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_err_28 got %b want 1", wr_err);
    end
    @(negedge clk);
    vectors++;
    if (wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_err_28_clear got %b want 0", wr_err);
    end
    wr(50, 16'hAAAA);
    vectors++;
    if (wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_err_50 got %b want 1", wr_err);
    end
    @(negedge clk);
    vectors++;
    if (wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_err_50_clear got %b want 0", wr_err);
    end
    strobe(28, 3, 32'h1111, 32'hFF);
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    vectors++;
    if ({16'h0, Data_A} !== ea || {16'h0, Data_B} !== eb) begin
      miscompares++;
      $display("FAIL ro_read_pi0 got A=%h B=%h want %h %h", Data_A, Data_B, ea, eb);
    end
    strobe(27, 50, 32'hBEEF, 32'h0);
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    vectors++;
    if ({16'h0, Data_A} !== ea || {16'h0, Data_B} !== eb || po0 !== 16'h0F0F || po1 !== 16'h0) begin
      miscompares++;
      $display("FAIL ro_unchanged got A=%h B=%h po0=%h po1=%h want %h %h 0f0f 0000",
               Data_A, Data_B, po0, po1, ea, eb);
    end
  endtask

  task automatic test_back_to_back_sync;
    @(negedge clk);
    pi1 = 16'h5A5A; updateBlock = 1; Sel_A = 29; Sel_B = 0;
    exp_q.push_back(32'h0);    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);    exp_q.push_back(32'h0);
    exp_q.push_back(32'h5A5A); exp_q.push_back(32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) updateBlock = 0;
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      vectors++;
      if ({16'h0, Data_A} !== ea || {16'h0, Data_B} !== eb || data_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL pi1_sync_edge%0d got A=%h B=%h dv=%b want %h %h 1", k + 1, Data_A, Data_B, data_valid, ea, eb);
      end
    end
  endtask

  task automatic test_param;
    logic [31:0] xa, xb;
    @(negedge clk);
    p_wr_en = 1; p_wr_addr = 7; p_wr_data = 32'hDEADBEEF;
    @(negedge clk);
    p_wr_addr = 9;
    @(negedge clk);
    p_wr_en = 0;
    vectors++;
    if (p_wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL p_wr_err_9 got %b want 1", p_wr_err);
    end
    @(negedge clk);
    p_updateBlock = 1; p_Sel_A = 7; p_Sel_B = 9;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0);
    @(negedge clk);
    p_updateBlock = 0;
    xa = exp_q.pop_front(); xb = exp_q.pop_front();
    vectors++;
    if (p_Data_A !== xa || p_Data_B !== xb || p_data_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL p_read got A=%h B=%h dv=%b want %h %h 1", p_Data_A, p_Data_B, p_data_valid, xa, xb);
    end
    @(negedge clk);
    p_wr_en = 1; p_wr_addr = 31; p_wr_data = 32'h12345678;
    @(negedge clk);
    p_wr_en = 0;
    vectors++;
    if (p_po1 !== 32'h12345678 || p_wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL p_po1 got %h err=%b want 12345678 0", p_po1, p_wr_err);
    end
  endtask

  initial begin
    test_reset;
    test_reset_unmapped;
    test_write_read;
    test_bypass;
    test_read_only;
    test_back_to_back_sync;
    test_param;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
